// File: rtl/regdelay_ctrl.sv
// Ready/valid flow controller for an N-deep step-enabled delay line.
// Tracks per-stage valid bits and drives the shared step/clear, with drain and flush modes.
module regdelay_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic          drain,
    input  logic          flush,
    output logic          dp_step,
    output logic          dp_clr,
    output logic          busy,
    output logic          drain_done,
    output logic [CW-1:0] occupancy
);

    typedef enum logic [1:0] {st_run, st_drain, st_flush} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  v_q, v_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          done_q, done_d;
    logic          adv, accept, pop;

    // Single global step: the line moves whenever the output slot is empty or being consumed.
    assign adv        = ~v_q[N-1] | m_ready;
    assign m_valid    = v_q[N-1];
    assign occupancy  = occ_q;
    assign drain_done = done_q;
    assign busy       = (state_q != st_run) | (occ_q != '0);

    always_comb begin
        dp_step = 1'b0;
        s_ready = 1'b0;
        dp_clr  = 1'b0;
        unique case (state_q)
            st_run: begin
                dp_step = adv;
                s_ready = adv;
            end
            st_drain: dp_step = adv;
            st_flush: dp_clr = 1'b1;
            default: ;
        endcase
    end

    assign accept = s_valid & s_ready;
    assign pop    = m_valid & m_ready & dp_step;

    always_comb begin
        v_d   = v_q;
        occ_d = occ_q + CW'(accept) - CW'(pop);
        if (dp_clr) begin
            v_d   = '0;
            occ_d = '0;
        end else if (dp_step) begin
            v_d[0] = accept;
            for (int i = 1; i < N; i++) begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            st_run: begin
                if (flush) begin
                    state_d = st_flush;
                end else if (drain) begin
                    state_d = st_drain;
                end
            end
            st_drain: begin
                if (flush) begin
                    state_d = st_flush;
                end else if (occ_d == '0) begin
                    state_d = st_run;
                    done_d  = 1'b1;
                end
            end
            st_flush: state_d = st_run;
            default:  state_d = st_run;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= st_run;
            v_q     <= '0;
            occ_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
        end
    end

    occ_matches_valid: assert property (@(posedge clk) disable iff (!clr_n)
        occ_q == CW'($countones(v_q)));

    clr_step_exclusive: assert property (@(posedge clk) disable iff (!clr_n)
        !(dp_clr && dp_step));

endmodule

// File: tb/tb_regdelay_ctrl.sv
// Bench for regdelay_ctrl: N=4 and N=1 instances driven in lockstep,
// each compared every cycle against a slot-array model of the delay line.
module tb_regdelay_ctrl;

    localparam int CW = 7;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    s_valid, s_ready, m_valid, m_ready, drain, flush;
    logic [1:0]    dp_step, dp_clr, busy, drain_done;
    logic [CW-1:0] occ_a, occ_b;

    int checks = 0;
    int errors = 0;

    regdelay_ctrl #(.N(4), .CW(CW)) dut_a (
        .clk(clk), .clr_n(clr_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .drain(drain[0]), .flush(flush[0]),
        .dp_step(dp_step[0]), .dp_clr(dp_clr[0]),
        .busy(busy[0]), .drain_done(drain_done[0]),
        .occupancy(occ_a)
    );

    regdelay_ctrl #(.N(1), .CW(CW)) dut_b (
        .clk(clk), .clr_n(clr_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .drain(drain[1]), .flush(flush[1]),
        .dp_step(dp_step[1]), .dp_clr(dp_clr[1]),
        .busy(busy[1]), .drain_done(drain_done[1]),
        .occupancy(occ_b)
    );

    // Model: slot bits per instance, mode 0=run 1=drain 2=flush, registered done pulse.
    int        depth [2] = '{4, 1};
    bit [63:0] ln [2];
    int        md [2];
    bit        dn [2];
    bit        xr [2];
    bit        xs [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ln[k] = '0;
            md[k] = 0;
            dn[k] = 1'b0;
        end
    endtask

    task automatic expect_outputs(input int k, input string ph);
        bit   outv;
        bit   adv;
        int   cnt;
        logic [CW-1:0] occ;
        string pre;
        outv  = ln[k][depth[k]-1];
        adv   = !outv || m_ready[k];
        cnt   = $countones(ln[k]);
        xs[k] = (md[k] != 2) && adv;
        xr[k] = (md[k] == 0) && adv;
        occ   = (k == 0) ? occ_a : occ_b;
        pre   = $sformatf("%s n%0d", ph, depth[k]);
        check({pre, " m_valid"}, 32'(m_valid[k]), 32'(outv));
        check({pre, " s_ready"}, 32'(s_ready[k]), 32'(xr[k]));
        check({pre, " dp_step"}, 32'(dp_step[k]), 32'(xs[k]));
        check({pre, " dp_clr"}, 32'(dp_clr[k]), 32'(md[k] == 2));
        check({pre, " busy"}, 32'(busy[k]), 32'((md[k] != 0) || (cnt != 0)));
        check({pre, " drain_done"}, 32'(drain_done[k]), 32'(dn[k]));
        check({pre, " occupancy"}, 32'(occ), 32'(cnt));
    endtask

    task automatic model_step(input int k);
        bit        acc;
        bit [63:0] mask;
        acc   = s_valid[k] && xr[k];
        mask  = (64'd1 << depth[k]) - 64'd1;
        dn[k] = 1'b0;
        if (md[k] == 2) begin
            ln[k] = '0;
            md[k] = 0;
        end else begin
            if (xs[k]) ln[k] = ((ln[k] << 1) | 64'(acc)) & mask;
            if (flush[k]) begin
                md[k] = 2;
            end else if (md[k] == 0) begin
                if (drain[k]) md[k] = 1;
            end else if ($countones(ln[k]) == 0) begin
                md[k] = 0;
                dn[k] = 1'b1;
            end
        end
    endtask

    task automatic run_cycle(input logic [1:0] sv, input logic [1:0] mr,
                             input logic [1:0] dr, input logic [1:0] fl, input string ph);
        @(negedge clk);
        clr_n   = 1'b1;
        s_valid = sv;
        m_ready = mr;
        drain   = dr;
        flush   = fl;
        #1;
        for (int k = 0; k < 2; k++) expect_outputs(k, ph);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
    endtask

    task automatic do_reset(input string ph);
        @(negedge clk);
        clr_n   = 1'b0;
        s_valid = '0;
        m_ready = '0;
        drain   = '0;
        flush   = '0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) expect_outputs(k, ph);
    endtask

    initial begin
        logic [1:0] sv, mr, dr, fl;
        s_valid = '0;
        m_ready = '0;
        drain   = '0;
        flush   = '0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) expect_outputs(k, "reset");

        // Streaming from reset, then stall on a full line and release.
        for (int i = 0; i < 12; i++) run_cycle(2'b11, 2'b11, 2'b00, 2'b00, "stream");
        for (int i = 0; i < 8; i++)  run_cycle(2'b11, 2'b00, 2'b00, 2'b00, "stall");
        for (int i = 0; i < 4; i++)  run_cycle(2'b11, 2'b11, 2'b00, 2'b00, "unstall");

        // Single beat, then drain to completion.
        run_cycle(2'b00, 2'b11, 2'b00, 2'b00, "idle");
        for (int i = 0; i < 6; i++)  run_cycle(2'b00, 2'b11, 2'b00, 2'b00, "empty");
        run_cycle(2'b11, 2'b11, 2'b00, 2'b00, "single");
        for (int i = 0; i < 7; i++)  run_cycle(2'b11, 2'b11, 2'b11, 2'b00, "drain");
        run_cycle(2'b00, 2'b11, 2'b00, 2'b00, "post_drain");

        // Partial fill, then flush alone and flush+drain together.
        for (int i = 0; i < 3; i++)  run_cycle(2'b11, 2'b00, 2'b00, 2'b00, "fill3");
        run_cycle(2'b00, 2'b00, 2'b00, 2'b11, "flush");
        run_cycle(2'b00, 2'b00, 2'b00, 2'b00, "post_flush");
        for (int i = 0; i < 2; i++)  run_cycle(2'b11, 2'b00, 2'b00, 2'b00, "fill2");
        for (int i = 0; i < 4; i++)  run_cycle(2'b00, 2'b00, 2'b11, 2'b11, "flush_drain");
        for (int i = 0; i < 3; i++)  run_cycle(2'b00, 2'b00, 2'b11, 2'b00, "drain_after");
        run_cycle(2'b00, 2'b00, 2'b00, 2'b00, "settle");

        // Reset in the middle of a stalled drain, then resume accepting.
        for (int i = 0; i < 2; i++)  run_cycle(2'b11, 2'b00, 2'b00, 2'b00, "fill_r");
        for (int i = 0; i < 3; i++)  run_cycle(2'b00, 2'b00, 2'b11, 2'b00, "drain_hold");
        do_reset("mid_drain_reset");
        for (int i = 0; i < 6; i++)  run_cycle(2'b11, 2'b11, 2'b00, 2'b00, "resume");

        // Randomized traffic with held drain levels, flush pulses and occasional resets.
        dr = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                sv[k] = ($urandom_range(99) < 70);
                mr[k] = ($urandom_range(99) < 60);
                if ($urandom_range(99) < 8) dr[k] = ~dr[k];
                fl[k] = ($urandom_range(99) < 3);
            end
            if ((i % 500) == 499) begin
                do_reset("rand_reset");
            end else begin
                run_cycle(sv, mr, dr, fl, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
